// File: rtl/msx_bus_bridge_fifo.sv
// msx_bus_bridge_fifo: MSX slot to host bridge with event FIFO and WAIT-stretched reads
//   clk, zrst              bridge clock, asynchronous active-low reset
//   zmreq ziorq zrd zwr    Z80 strobes, active-low, asynchronous to clk
//   msltsl, a              slot select (active-low) and Z80 address
//   d_in, d_out, d_oe, mbd Z80 data sample, read data, drive enable, bus direction
//   zwait                  active-low WAIT to the Z80
//   RATN, cmd, r_in        host command strobe, code and data
//   r_out, ACK, ATN        host result, acknowledge, FIFO non-empty attention
//   status                 {overflow, timeout, read_pending, fifo_full}
module msx_bus_bridge_fifo #(
   parameter int FIFO_DEPTH   = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int WAIT_TIMEOUT = 1024,
   parameter int IO_PORTS     = 256
) (
   input  logic        clk,
   input  logic        zrst,
   input  logic        zmreq,
   input  logic        ziorq,
   input  logic        zrd,
   input  logic        zwr,
   input  logic        msltsl,
   input  logic [15:0] a,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   output logic        d_oe,
   output logic        zwait,
   output logic        mbd,
   input  logic        RATN,
   input  logic [2:0]  cmd,
   input  logic [15:0] r_in,
   output logic [15:0] r_out,
   output logic        ACK,
   output logic        ATN,
   output logic [3:0]  status
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(WAIT_TIMEOUT + 1);
   localparam int IW = IO_PORTS > 1 ? $clog2(IO_PORTS) : 1;

   typedef enum logic [2:0] {IDLE, CAPTURE, WR_DATA, WR_HOLD, RD_WAIT, RD_DRIVE} state_t;
   state_t state, state_n;

   logic [5:0]          sy [SYNC_STAGES];
   logic                s_mreq, s_iorq, s_rd, s_wr, s_msl, s_ratn;
   logic                sel_d, iorq_d, ratn_d;
   logic                mem_det, io_det, rise, released;
   logic [IO_PORTS-1:0] io_en;
   logic [IW-1:0]       io_idx, cfg_idx;
   logic                typ_q;
   logic [15:0]         addr_q;
   logic [TW-1:0]       tmr;
   logic                ovf, tmo;
   logic [25:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]       wp, rp;
   logic [CW-1:0]       cnt;
   logic [5:0]          cnt6;
   logic [25:0]         head, entry;
   logic                full, empty, pop, clr, flush, push_ok;
   logic                push, push_dir, drive, undrive, wait_on, tmo_set, data_cmd;
   logic [7:0]          wr_data, drv_val;
   logic                unused_rin;

   assign {s_ratn, s_msl, s_wr, s_rd, s_iorq, s_mreq} = sy[SYNC_STAGES-1];
   assign unused_rin = ^r_in[14:9];

   // strobes idle high, RATN idle low
   always_ff @(posedge clk or negedge zrst)
      if (!zrst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sy[k] <= 6'b011111;
         sel_d  <= 1'b1;
         iorq_d <= 1'b1;
         ratn_d <= 1'b0;
      end else begin
         sy[0] <= {RATN, msltsl, zwr, zrd, ziorq, zmreq};
         for (int k = 1; k < SYNC_STAGES; k++) sy[k] <= sy[k-1];
         sel_d  <= s_msl | s_mreq;
         iorq_d <= s_iorq;
         ratn_d <= s_ratn;
      end

   assign io_idx   = IW'(32'(a[7:0]) % IO_PORTS);
   assign cfg_idx  = IW'(32'(r_in[7:0]) % IO_PORTS);
   assign mem_det  = sel_d & ~s_msl & ~s_mreq;
   assign io_det   = iorq_d & ~s_iorq & io_en[io_idx];
   assign released = typ_q ? s_iorq : (s_msl | s_mreq);
   assign rise     = s_ratn & ~ratn_d;
   assign full     = cnt == CW'(FIFO_DEPTH);
   assign empty    = cnt == '0;
   assign head     = mem[rp];
   assign pop      = rise & (cmd == 3'b001) & ~empty;
   assign clr      = rise & (cmd == 3'b101);
   assign flush    = clr & r_in[15];
   assign data_cmd = rise & (cmd == 3'b010) & (state == RD_WAIT);
   // a pop in the same clk frees the slot a full FIFO needs
   assign push_ok  = ~full | pop;
   assign entry    = {typ_q, push_dir, addr_q, wr_data};
   assign cnt6     = 6'(cnt);
   assign ATN      = ~empty;
   assign status   = {ovf, tmo, state == RD_WAIT, full};

   always_ff @(posedge clk or negedge zrst)
      if (!zrst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n  = state;
      push     = 1'b0;
      push_dir = 1'b0;
      wr_data  = 8'h00;
      drive    = 1'b0;
      drv_val  = 8'hFF;
      undrive  = 1'b0;
      wait_on  = 1'b0;
      tmo_set  = 1'b0;
      case (state)
         IDLE: if (mem_det | io_det) state_n = CAPTURE;
         CAPTURE:
            if (!s_rd) begin
               push     = 1'b1;
               push_dir = 1'b1;
               // a dropped read is answered with FF straight away
               wait_on  = push_ok;
               drive    = ~push_ok;
               state_n  = push_ok ? RD_WAIT : RD_DRIVE;
            end else if (!s_wr) begin
               push    = 1'b1;
               wr_data = d_in;
               state_n = WR_HOLD;
            end else state_n = WR_DATA;
         // WR trails the request strobe; a cycle ending with no WR (refresh) is not an event
         WR_DATA:
            if (!s_wr) begin
               push    = 1'b1;
               wr_data = d_in;
               state_n = WR_HOLD;
            end else if (released) state_n = IDLE;
         WR_HOLD: if (released) state_n = IDLE;
         RD_WAIT:
            if (data_cmd) begin
               drive   = 1'b1;
               drv_val = r_in[7:0];
               state_n = RD_DRIVE;
            end else if (tmr == TW'(WAIT_TIMEOUT - 1)) begin
               drive   = 1'b1;
               tmo_set = 1'b1;
               state_n = RD_DRIVE;
            end
         RD_DRIVE:
            if (s_rd) begin
               undrive = 1'b1;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge zrst)
      if (!zrst) begin
         typ_q  <= 1'b0;
         addr_q <= '0;
         tmr    <= '0;
         zwait  <= 1'b1;
         d_out  <= '0;
         d_oe   <= 1'b0;
         mbd    <= 1'b1;
         ovf    <= 1'b0;
         tmo    <= 1'b0;
      end else begin
         if (state == IDLE && (mem_det | io_det)) begin
            typ_q  <= ~mem_det;
            addr_q <= a;
         end
         // free-running; only compared while in RD_WAIT, cleared on entry
         tmr <= wait_on ? '0 : tmr + TW'(1);
         if (wait_on) zwait <= 1'b0;
         if (drive) begin
            zwait <= 1'b1;
            d_out <= drv_val;
            d_oe  <= 1'b1;
            mbd   <= 1'b0;
         end
         if (undrive) begin
            d_oe <= 1'b0;
            mbd  <= 1'b1;
         end
         if (clr) begin
            ovf <= 1'b0;
            tmo <= 1'b0;
         end
         if (push & ~push_ok) ovf <= 1'b1;
         if (tmo_set) tmo <= 1'b1;
      end

   always_ff @(posedge clk or negedge zrst)
      if (!zrst) begin
         ACK   <= 1'b0;
         r_out <= '0;
         io_en <= '0;
      end else begin
         if (rise) ACK <= 1'b1;
         else if (!s_ratn) ACK <= 1'b0;
         if (rise)
            case (cmd)
               3'b000:  r_out <= empty ? '0 : head[23:8];
               3'b001:  r_out <= empty ? '0 : {head[25:24], ovf, tmo, 4'b0000, head[7:0]};
               3'b011:  io_en[cfg_idx] <= r_in[8];
               3'b100:  r_out <= {status, cnt6, 6'b000000};
               default: ;
            endcase
      end

   always_ff @(posedge clk or negedge zrst)
      if (!zrst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (pop) rp <= rp + AW'(1);
         if (push & push_ok) wp <= wp + AW'(1);
         cnt <= cnt + CW'(push & push_ok) - CW'(pop);
      end

   always_ff @(posedge clk)
      if (push & push_ok) mem[wp] <= entry;

endmodule

// File: tb/tb_msx_bus_bridge_fifo.sv
// tb_msx_bus_bridge_fifo: table, directed and randomized checks of msx_bus_bridge_fifo
module tb_msx_bus_bridge_fifo;
   localparam int DEPTH = 8;
   localparam int TMO   = 1024;

   logic        clk = 0, zrst = 0;
   logic        zmreq = 1, ziorq = 1, zrd = 1, zwr = 1, msltsl = 1, RATN = 0;
   logic [15:0] a = 0, r_in = 0;
   logic [7:0]  d_in = 0;
   logic [2:0]  cmd = 0;
   logic [7:0]  d_out;
   logic        d_oe, zwait, mbd, ACK, ATN;
   logic [15:0] r_out;
   logic [3:0]  status;
   int          checks = 0, failures = 0;

   msx_bus_bridge_fifo dut (
      .clk(clk), .zrst(zrst), .zmreq(zmreq), .ziorq(ziorq), .zrd(zrd), .zwr(zwr),
      .msltsl(msltsl), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .zwait(zwait),
      .mbd(mbd), .RATN(RATN), .cmd(cmd), .r_in(r_in), .r_out(r_out), .ACK(ACK),
      .ATN(ATN), .status(status)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          op;
      logic [15:0] ad;
      logic [7:0]  dt;
      logic [2:0]  c;
      logic [15:0] rin;
      bit          ck;
      logic [15:0] er;
      bit          eatn;
   } vec_t;
   vec_t tv [20];

   logic [25:0] q [$];
   bit          m_ovf, m_tmo;
   bit          m_en [256];

   function automatic void m_push(input logic [25:0] e);
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(e);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic host_cmd(input logic [2:0] c, input logic [15:0] ri, output logic [15:0] ro);
      int n;
      cmd = c;
      r_in = ri;
      RATN = 1;
      n = 0;
      while (!ACK && n < 20) begin tick(); n++; end
      chk("ack_rise", ACK, 1);
      ro = r_out;
      RATN = 0;
      n = 0;
      while (ACK && n < 20) begin tick(); n++; end
      chk("ack_fall", ACK, 0);
   endtask

   task automatic bus_write(input bit io, input bit sel, input logic [15:0] ad, input logic [7:0] dt);
      a = ad;
      d_in = dt;
      if (io) ziorq = 0;
      else begin
         zmreq = 0;
         msltsl = !sel;
      end
      repeat (3) tick();
      zwr = 0;
      repeat (5) tick();
      zwr = 1; ziorq = 1; zmreq = 1; msltsl = 1;
      repeat (5) tick();
   endtask

   task automatic read_start(input logic [15:0] ad);
      a = ad;
      msltsl = 0; zmreq = 0; zrd = 0;
   endtask

   task automatic wait_zwait_low();
      int n = 0;
      while (zwait && n < 30) begin tick(); n++; end
      chk("zwait_low", zwait, 0);
   endtask

   task automatic read_release();
      int n = 0;
      zrd = 1; zmreq = 1; msltsl = 1;
      while (d_oe && n < 30) begin tick(); n++; end
      chk("release_oe", d_oe, 0);
      chk("release_mbd", mbd, 1);
      repeat (3) tick();
   endtask

   initial begin
      logic [15:0] ro, ad;
      logic [7:0]  dt, p;
      logic [25:0] e;
      logic [15:0] ex;
      int          n, op;
      bit          en, seen_low, fl;

      tv[0]  = '{2, 16'h0000, 8'h00, 3'd4, 16'h0000, 1, 16'h0000, 0};
      tv[1]  = '{2, 16'h0000, 8'h00, 3'd3, 16'h0198, 0, 16'h0000, 0};
      tv[2]  = '{0, 16'h0098, 8'h5A, 3'd0, 16'h0000, 0, 16'h0000, 1};
      tv[3]  = '{2, 16'h0000, 8'h00, 3'd0, 16'h0000, 1, 16'h0098, 1};
      tv[4]  = '{2, 16'h0000, 8'h00, 3'd4, 16'h0000, 1, 16'h0040, 1};
      tv[5]  = '{2, 16'h0000, 8'h00, 3'd1, 16'h0000, 1, 16'h805A, 0};
      tv[6]  = '{0, 16'h0099, 8'h11, 3'd0, 16'h0000, 0, 16'h0000, 0};
      tv[7]  = '{2, 16'h0000, 8'h00, 3'd3, 16'h0199, 0, 16'h0000, 0};
      tv[8]  = '{0, 16'h1299, 8'h22, 3'd0, 16'h0000, 0, 16'h0000, 1};
      tv[9]  = '{2, 16'h0000, 8'h00, 3'd2, 16'h00AA, 0, 16'h0000, 1};
      tv[10] = '{2, 16'h0000, 8'h00, 3'd0, 16'h0000, 1, 16'h1299, 1};
      tv[11] = '{2, 16'h0000, 8'h00, 3'd1, 16'h0000, 1, 16'h8022, 0};
      tv[12] = '{1, 16'h8123, 8'h77, 3'd0, 16'h0000, 0, 16'h0000, 1};
      tv[13] = '{2, 16'h0000, 8'h00, 3'd6, 16'h0000, 0, 16'h0000, 1};
      tv[14] = '{2, 16'h0000, 8'h00, 3'd1, 16'h0000, 1, 16'h0077, 0};
      tv[15] = '{2, 16'h0000, 8'h00, 3'd1, 16'h0000, 1, 16'h0000, 0};
      tv[16] = '{2, 16'h0000, 8'h00, 3'd0, 16'h0000, 1, 16'h0000, 0};
      tv[17] = '{2, 16'h0000, 8'h00, 3'd3, 16'h0098, 0, 16'h0000, 0};
      tv[18] = '{0, 16'h0098, 8'h33, 3'd0, 16'h0000, 0, 16'h0000, 0};
      tv[19] = '{2, 16'h0000, 8'h00, 3'd4, 16'h0000, 1, 16'h0000, 0};

      repeat (3) tick();
      chk("rst_zwait", zwait, 1);
      chk("rst_d_oe", d_oe, 0);
      chk("rst_mbd", mbd, 1);
      chk("rst_ack", ACK, 0);
      chk("rst_atn", ATN, 0);
      chk("rst_r_out", r_out, 0);
      chk("rst_status", status, 0);
      zrst = 1;
      repeat (3) tick();

      for (int i = 0; i < 20; i++) begin
         case (tv[i].op)
            0: bus_write(1, 1, tv[i].ad, tv[i].dt);
            1: bus_write(0, 1, tv[i].ad, tv[i].dt);
            default: begin
               host_cmd(tv[i].c, tv[i].rin, ro);
               if (tv[i].ck) chk($sformatf("vec%0d_r_out", i), ro, tv[i].er);
            end
         endcase
         chk($sformatf("vec%0d_atn", i), ATN, tv[i].eatn);
      end

      read_start(16'h4000);
      wait_zwait_low();
      repeat (20) tick();
      chk("rd_still_wait", zwait, 0);
      chk("rd_pending", status, 4'b0010);
      host_cmd(3'd2, 16'h00C3, ro);
      chk("rd_zwait_rel", zwait, 1);
      chk("rd_dout", d_out, 8'hC3);
      chk("rd_doe", d_oe, 1);
      chk("rd_mbd", mbd, 0);
      repeat (5) tick();
      chk("rd_hold", d_oe, 1);
      read_release();
      host_cmd(3'd1, 16'h0000, ro);
      chk("rd_pop", ro, 16'h4000);

      read_start(16'h5000);
      wait_zwait_low();
      n = 0;
      while (!zwait && n < 3000) begin tick(); n++; end
      chk("tmo_len", n, TMO);
      chk("tmo_dout", d_out, 8'hFF);
      chk("tmo_doe", d_oe, 1);
      chk("tmo_flag", status[2], 1);
      host_cmd(3'd4, 16'h0000, ro);
      chk("tmo_status", ro, 16'h4040);
      read_release();
      host_cmd(3'd5, 16'h8000, ro);
      chk("clear_status", status, 0);
      chk("clear_atn", ATN, 0);

      for (int i = 0; i < DEPTH + 1; i++) begin
         bus_write(0, 1, 16'h4000 + 16'(i), 8'(i));
         if (i == DEPTH - 1) chk("ovf_full", status, 4'b0001);
      end
      chk("ovf_status_port", status, 4'b1001);
      host_cmd(3'd4, 16'h0000, ro);
      chk("ovf_status_cmd", ro, 16'h9200);
      for (int i = 0; i < DEPTH; i++) begin
         host_cmd(3'd1, 16'h0000, ro);
         chk($sformatf("ovf_pop%0d", i), ro, 16'h2000 | 16'(i));
      end
      host_cmd(3'd1, 16'h0000, ro);
      chk("ovf_last_lost", ro, 0);
      host_cmd(3'd5, 16'h0000, ro);
      chk("ovf_cleared", status, 0);

      read_start(16'h6000);
      wait_zwait_low();
      chk("mid_atn_before", ATN, 1);
      @(posedge clk);
      #3;
      zrst = 0;
      #1;
      chk("mid_rst_zwait", zwait, 1);
      chk("mid_rst_atn", ATN, 0);
      chk("mid_rst_ack", ACK, 0);
      chk("mid_rst_doe", d_oe, 0);
      zrd = 1; zmreq = 1; msltsl = 1;
      repeat (3) tick();
      zrst = 1;
      repeat (3) tick();

      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: begin
               p = 8'h10 + 8'($urandom_range(0, 3));
               en = 1'($urandom_range(0, 1));
               host_cmd(3'd3, {7'b0, en, p}, ro);
               m_en[p] = en;
            end
            1: begin
               p = 8'h10 + 8'($urandom_range(0, 3));
               ad = {8'($urandom), p};
               dt = 8'($urandom);
               bus_write(1, 1, ad, dt);
               if (m_en[p]) m_push({1'b1, 1'b0, ad, dt});
            end
            2: begin
               ad = 16'($urandom);
               dt = 8'($urandom);
               en = $urandom_range(0, 3) != 0;
               bus_write(0, en, ad, dt);
               if (en) m_push({1'b0, 1'b0, ad, dt});
            end
            3: begin
               ad = 16'($urandom);
               dt = 8'($urandom);
               read_start(ad);
               if (q.size() == DEPTH) begin
                  seen_low = 0;
                  n = 0;
                  while (!d_oe && n < 30) begin
                     if (!zwait) seen_low = 1;
                     tick();
                     n++;
                  end
                  chk("drop_doe", d_oe, 1);
                  chk("drop_dout", d_out, 8'hFF);
                  chk("drop_nowait", seen_low, 0);
               end else begin
                  wait_zwait_low();
                  host_cmd(3'd2, {8'h00, dt}, ro);
                  chk("rnd_rd_dout", d_out, dt);
                  chk("rnd_rd_zwait", zwait, 1);
               end
               m_push({1'b0, 1'b1, ad, 8'h00});
               read_release();
            end
            4: begin
               if (q.size() == 0) ex = 0;
               else begin
                  e = q.pop_front();
                  ex = {e[25:24], m_ovf, m_tmo, 4'b0000, e[7:0]};
               end
               host_cmd(3'd1, 16'h0000, ro);
               chk("rnd_pop", ro, ex);
            end
            5: begin
               ex = q.size() == 0 ? 16'h0000 : q[0][23:8];
               host_cmd(3'd0, 16'h0000, ro);
               chk("rnd_peek", ro, ex);
            end
            6: begin
               ex = {m_ovf, m_tmo, 1'b0, q.size() == DEPTH, 6'(q.size()), 6'b000000};
               host_cmd(3'd4, 16'h0000, ro);
               chk("rnd_status", ro, ex);
            end
            default: begin
               fl = $urandom_range(0, 3) == 0;
               host_cmd(3'd5, fl ? 16'h8000 : 16'h0000, ro);
               m_ovf = 0;
               m_tmo = 0;
               if (fl) q.delete();
            end
         endcase
         chk("rnd_atn", ATN, q.size() != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
